resp_scheduler: RTL and testbench
=================================

# resp_scheduler

Sequences the UART response frame builder and shares it between two requesters: the command path (read/write responses to host commands) and the event path (unsolicited error/status reports). It arbitrates round-robin, latches the winner's header fields, and issues a single-cycle launch pulse. It waits for frame completion, then returns a completion pulse to the winning requester. It sits between the command/AXI master logic and the frame builder, upstream of the UART TX FIFO.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: watchdog limit in WAIT. Used only with RESP_SCHED_TIMEOUT_EN.
- TO_W, 13: watchdog counter width. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_req  in  1  command-path response request, level; held until cmd_ack
- cmd_status  in  8  status code
- cmd_code  in  8  command echo
- cmd_addr  in  32  address echo
- cmd_count  in  6  read data byte count
- cmd_is_read  in  1  read response flag
- cmd_ack  out  1  one-cycle grant pulse; fields captured
- cmd_done  out  1  one-cycle frame-finished pulse
- evt_req  in  1  event report request, level; held until evt_ack
- evt_status  in  8  event status code
- evt_code  in  8  event code echo
- evt_ack  out  1  one-cycle grant pulse
- evt_done  out  1  one-cycle frame-finished pulse
- fb_status_code  out  8  to builder
- fb_cmd_echo  out  8  to builder
- fb_addr_echo  out  32  to builder
- fb_data_count  out  6  to builder
- fb_is_read  out  1  to builder
- fb_build_response  out  1  builder launch; one-cycle pulse
- fb_busy  in  1  builder busy
- fb_complete  in  1  builder done pulse
- sched_busy  out  1  state != IDLE
- grant_id  out  1  0 = cmd, 1 = evt; last/current owner
- frame_count  out  16  frames completed, wraps at 0xFFFF → 0
- timeout_flag  out  1  sticky watchdog flag
- timeout_clr  in  1  clears timeout_flag

## Operation
The builder's response_data array is wired directly from the command path. The scheduler does not carry it. Event frames always use fb_data_count = 0 and fb_is_read = 0.

States:
- IDLE: if (cmd_req | evt_req) and !fb_busy, select a winner and go to LAUNCH.
  - Select: if only one requests, it wins.
  - If both request, the source not equal to last_grant wins (round-robin).
  - last_grant resets to evt, so cmd wins the first tie.
- LAUNCH (1 cycle):
  - Registered fb_* fields hold the winner's values.
  - fb_build_response = 1.
  - Winner's ack = 1.
  - grant_id and last_grant are updated.
  - Next state: WAIT.
- WAIT: fb_* fields are held stable and fb_build_response = 0.
  - On fb_complete, go to RELEASE.
- RELEASE (1 cycle):
  - Winner's done = 1.
  - frame_count increments.
  - Next state: IDLE.

Rules:
- A request seen during LAUNCH, WAIT or RELEASE stays pending. It is arbitrated on return to IDLE.
- A requester must not deassert req before ack. Field values after ack are don't-care.
- fb_complete outside WAIT is ignored.
- fb_build_response is low for at least 2 cycles between launches. This guarantees the builder sees a fresh rising edge.
- timeout_clr has priority over a same-cycle set of timeout_flag.
- Reset during any state:
  - Return to IDLE.
  - All outputs go to 0, and the watchdog clears.
  - Requests still asserted after reset are re-arbitrated normally.

## Timing
Reset values:
- All outputs are 0: cmd_ack, cmd_done, evt_ack, evt_done, every fb_* field, fb_build_response, sched_busy, grant_id, frame_count, timeout_flag.
- State is IDLE and last_grant = evt.

Cycle-level latencies:
- req sampled high in IDLE at cycle N → LAUNCH at N+1, with ack, fb_build_response and valid fields all registered together.
- WAIT starts at N+2.
- fb_complete sampled at cycle M → done at M+1 → IDLE at M+2.
- Earliest next LAUNCH is M+3.
- fb_busy high in IDLE blocks the launch until the first cycle it is low.

## Configuration
Macro: RESP_SCHED_TIMEOUT_EN.

Defined:
- A watchdog counts cycles in WAIT.
- When the count reaches TIMEOUT_CYCLES without fb_complete:
  - Set timeout_flag.
  - Pulse the winner's done.
  - Do not increment frame_count.
  - Go to IDLE.
- The IDLE fb_busy gate still applies afterwards.

Not defined:
- There is no counter and WAIT waits indefinitely.
- timeout_flag is tied to 0 and timeout_clr is ignored.

## Test plan
- Single cmd: cmd_req with status 0x00, code 0x81, addr 0x1000_0040, count 4, is_read 1.
  - Expect cmd_ack and fb_build_response at N+1, with fb fields equal to those values.
  - Builder completes; expect cmd_done 1 cycle after fb_complete and frame_count = 1.
- Simultaneous cmd_req and evt_req after reset:
  - cmd is granted first (grant_id 0).
  - evt is granted next, with fb_data_count 0 and fb_is_read 0.
  - A second tie alternates again.
- evt_req raised during a cmd frame's WAIT:
  - No second fb_build_response until after cmd_done.
  - evt LAUNCH occurs exactly 2 cycles after cmd_done.
- fb_busy held high in IDLE with cmd_req pending: no launch until fb_busy falls; launch on the next cycle.
- Timeout (macro on), TIMEOUT_CYCLES = 16, builder never completes:
  - Expect timeout_flag = 1 and cmd_done after 16 WAIT cycles, with frame_count unchanged.
  - timeout_clr then clears the flag.
- Reset asserted in WAIT: all outputs go to 0. With cmd_req still high after reset, the request is relaunched at reset release + 1 cycle.

Source files
------------

// File: rtl/resp_scheduler_if.sv
// Handshake bundle between resp_scheduler, its two requesters (command and event
// paths) and the UART response frame builder.
interface resp_scheduler_if;
  logic        cmd_req;
  logic [7:0]  cmd_status;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_addr;
  logic [5:0]  cmd_count;
  logic        cmd_is_read;
  logic        cmd_ack;
  logic        cmd_done;

  logic        evt_req;
  logic [7:0]  evt_status;
  logic [7:0]  evt_code;
  logic        evt_ack;
  logic        evt_done;

  logic [7:0]  fb_status_code;
  logic [7:0]  fb_cmd_echo;
  logic [31:0] fb_addr_echo;
  logic [5:0]  fb_data_count;
  logic        fb_is_read;
  logic        fb_build_response;
  logic        fb_busy;
  logic        fb_complete;

  logic        sched_busy;
  logic        grant_id;
  logic [15:0] frame_count;
  logic        timeout_flag;
  logic        timeout_clr;

  // Scheduler side.
  modport master (
    input  cmd_req, cmd_status, cmd_code, cmd_addr, cmd_count, cmd_is_read,
    input  evt_req, evt_status, evt_code,
    input  fb_busy, fb_complete, timeout_clr,
    output cmd_ack, cmd_done, evt_ack, evt_done,
    output fb_status_code, fb_cmd_echo, fb_addr_echo, fb_data_count, fb_is_read,
    output fb_build_response, sched_busy, grant_id, frame_count, timeout_flag
  );

  // Requester / builder side.
  modport slave (
    output cmd_req, cmd_status, cmd_code, cmd_addr, cmd_count, cmd_is_read,
    output evt_req, evt_status, evt_code,
    output fb_busy, fb_complete, timeout_clr,
    input  cmd_ack, cmd_done, evt_ack, evt_done,
    input  fb_status_code, fb_cmd_echo, fb_addr_echo, fb_data_count, fb_is_read,
    input  fb_build_response, sched_busy, grant_id, frame_count, timeout_flag
  );
endinterface

// File: rtl/resp_scheduler.sv
// Round-robin scheduler sharing the UART response frame builder between the command
// and event paths. Optional WAIT watchdog enabled by macro RESP_SCHED_TIMEOUT_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no frame in flight; arbitrate when a request is up and builder idle
// S_LAUNCH  | one cycle: fb_* fields valid, build pulse and winner's ack high
// S_WAIT    | fields held, waiting for fb_complete (or watchdog expiry)
// S_RELEASE | one cycle: winner's done pulse, then back to idle
module resp_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic              clk,
  input  logic              rst,
  resp_scheduler_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RELEASE} state_t;

  state_t state;
  logic   last_grant;
  logic   any_req;
  logic   winner;

  if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_to_w_check
    $error("resp_scheduler: TO_W too narrow for TIMEOUT_CYCLES");
  end

  assign any_req = bus.cmd_req | bus.evt_req;
  // On a tie the source that did not win last time gets the builder.
  assign winner  = (bus.cmd_req & bus.evt_req) ? ~last_grant : bus.evt_req;

`ifdef RESP_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign bus.timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= S_IDLE;
      last_grant            <= 1'b1;
      bus.cmd_ack           <= 1'b0;
      bus.cmd_done          <= 1'b0;
      bus.evt_ack           <= 1'b0;
      bus.evt_done          <= 1'b0;
      bus.fb_status_code    <= '0;
      bus.fb_cmd_echo       <= '0;
      bus.fb_addr_echo      <= '0;
      bus.fb_data_count     <= '0;
      bus.fb_is_read        <= 1'b0;
      bus.fb_build_response <= 1'b0;
      bus.sched_busy        <= 1'b0;
      bus.grant_id          <= 1'b0;
      bus.frame_count       <= '0;
`ifdef RESP_SCHED_TIMEOUT_EN
      to_cnt                <= '0;
      bus.timeout_flag      <= 1'b0;
`endif
    end else begin
      bus.cmd_ack           <= 1'b0;
      bus.evt_ack           <= 1'b0;
      bus.cmd_done          <= 1'b0;
      bus.evt_done          <= 1'b0;
      bus.fb_build_response <= 1'b0;

      case (state)
        S_IDLE: begin
          if (any_req && !bus.fb_busy) begin
            state                 <= S_LAUNCH;
            bus.sched_busy        <= 1'b1;
            bus.fb_build_response <= 1'b1;
            bus.grant_id          <= winner;
            last_grant            <= winner;
            if (winner) begin
              // Event frames carry no data payload and no address.
              bus.evt_ack        <= 1'b1;
              bus.fb_status_code <= bus.evt_status;
              bus.fb_cmd_echo    <= bus.evt_code;
              bus.fb_addr_echo   <= '0;
              bus.fb_data_count  <= '0;
              bus.fb_is_read     <= 1'b0;
            end else begin
              bus.cmd_ack        <= 1'b1;
              bus.fb_status_code <= bus.cmd_status;
              bus.fb_cmd_echo    <= bus.cmd_code;
              bus.fb_addr_echo   <= bus.cmd_addr;
              bus.fb_data_count  <= bus.cmd_count;
              bus.fb_is_read     <= bus.cmd_is_read;
            end
          end
        end

        S_LAUNCH: begin
          state <= S_WAIT;
`ifdef RESP_SCHED_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end

        S_WAIT: begin
          if (bus.fb_complete) begin
            state           <= S_RELEASE;
            bus.cmd_done    <= ~bus.grant_id;
            bus.evt_done    <= bus.grant_id;
            bus.frame_count <= bus.frame_count + 16'd1;
          end
`ifdef RESP_SCHED_TIMEOUT_EN
          else if (to_hit) begin
            // Abandoned frame: release the requester but do not count it.
            state            <= S_RELEASE;
            bus.cmd_done     <= ~bus.grant_id;
            bus.evt_done     <= bus.grant_id;
            bus.timeout_flag <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        S_RELEASE: begin
          state          <= S_IDLE;
          bus.sched_busy <= 1'b0;
        end

        default: begin
          state          <= S_IDLE;
          bus.sched_busy <= 1'b0;
        end
      endcase

`ifdef RESP_SCHED_TIMEOUT_EN
      if (bus.timeout_clr) bus.timeout_flag <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_resp_scheduler.sv
// Self-checking bench for resp_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a timeline-based reference model.
module tb_resp_scheduler;
`ifdef RESP_SCHED_TIMEOUT_EN
  localparam int TOC   = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TOC   = 4096;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  resp_scheduler_if bus();

  resp_scheduler #(.TIMEOUT_CYCLES(TOC), .TO_W(13)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected outputs after the most recent rising edge.
  logic        e_cmd_ack = 0, e_cmd_done = 0, e_evt_ack = 0, e_evt_done = 0;
  logic [7:0]  e_status = 0, e_code = 0;
  logic [31:0] e_addr = 0;
  logic [5:0]  e_count = 0;
  logic        e_isrd = 0, e_build = 0, e_busy = 0, e_grant = 0, e_tflag = 0;
  logic [15:0] e_frames = 0;

  // Model bookkeeping: frames are described by the cycle they launched and finished.
  bit m_busy = 0;
  bit m_last = 1;
  bit m_owner = 0;
  int m_launch_cyc = -10;
  int m_done_cyc = -10;
  int m_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    e_cmd_ack = 0; e_evt_ack = 0; e_cmd_done = 0; e_evt_done = 0; e_build = 0;
    if (rst) begin
      m_busy = 0; m_last = 1; m_done_cyc = -10; m_launch_cyc = -10;
      e_status = 0; e_code = 0; e_addr = 0; e_count = 0; e_isrd = 0;
      e_busy = 0; e_grant = 0; e_frames = 0; e_tflag = 0;
    end else begin
      if (!m_busy) begin
        if ((bus.cmd_req || bus.evt_req) && !bus.fb_busy) begin
          if (bus.cmd_req && bus.evt_req) m_owner = !m_last;
          else m_owner = bus.evt_req;
          m_last = m_owner; e_grant = m_owner; e_build = 1; e_busy = 1;
          m_busy = 1; m_launch_cyc = cyc; m_done_cyc = -10; m_wait = 0;
          if (m_owner) begin
            e_evt_ack = 1; e_status = bus.evt_status; e_code = bus.evt_code;
            e_addr = 0; e_count = 0; e_isrd = 0;
          end else begin
            e_cmd_ack = 1; e_status = bus.cmd_status; e_code = bus.cmd_code;
            e_addr = bus.cmd_addr; e_count = bus.cmd_count; e_isrd = bus.cmd_is_read;
          end
        end
      end else if (m_done_cyc == cyc - 1) begin
        m_busy = 0; e_busy = 0;
      end else if (m_launch_cyc != cyc - 1 && m_done_cyc < 0) begin
        if (bus.fb_complete) begin
          if (m_owner) e_evt_done = 1; else e_cmd_done = 1;
          e_frames = e_frames + 16'd1;
          m_done_cyc = cyc;
        end else begin
          m_wait++;
          if (TO_EN && m_wait == TOC) begin
            if (m_owner) e_evt_done = 1; else e_cmd_done = 1;
            e_tflag = 1;
            m_done_cyc = cyc;
          end
        end
      end
      if (bus.timeout_clr) e_tflag = 0;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("cmd_ack",       32'(bus.cmd_ack),           32'(e_cmd_ack));
      chk("cmd_done",      32'(bus.cmd_done),          32'(e_cmd_done));
      chk("evt_ack",       32'(bus.evt_ack),           32'(e_evt_ack));
      chk("evt_done",      32'(bus.evt_done),          32'(e_evt_done));
      chk("fb_status",     32'(bus.fb_status_code),    32'(e_status));
      chk("fb_cmd_echo",   32'(bus.fb_cmd_echo),       32'(e_code));
      chk("fb_addr_echo",  bus.fb_addr_echo,           e_addr);
      chk("fb_data_count", 32'(bus.fb_data_count),     32'(e_count));
      chk("fb_is_read",    32'(bus.fb_is_read),        32'(e_isrd));
      chk("fb_build",      32'(bus.fb_build_response), 32'(e_build));
      chk("sched_busy",    32'(bus.sched_busy),        32'(e_busy));
      chk("grant_id",      32'(bus.grant_id),          32'(e_grant));
      chk("frame_count",   32'(bus.frame_count),       32'(e_frames));
      chk("timeout_flag",  32'(bus.timeout_flag),      32'(e_tflag));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Called at the negedge of a LAUNCH cycle; completes after w WAIT cycles (w >= 1)
  // and returns at the negedge of the following IDLE cycle.
  task automatic finish_frame(input int w, input bit owner);
    repeat (w) step();
    bus.fb_complete = 1'b1;
    step();
    bus.fb_complete = 1'b0;
    if (owner) chk("lit_evt_done", 32'(bus.evt_done), 32'd1);
    else       chk("lit_cmd_done", 32'(bus.cmd_done), 32'd1);
    step();
  endtask

  bit bld_active = 0;
  int bld_cnt = 0;

  initial begin
    bus.cmd_req = 0; bus.cmd_status = 0; bus.cmd_code = 0; bus.cmd_addr = 0;
    bus.cmd_count = 0; bus.cmd_is_read = 0;
    bus.evt_req = 0; bus.evt_status = 0; bus.evt_code = 0;
    bus.fb_busy = 0; bus.fb_complete = 0; bus.timeout_clr = 0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("lit_rst_busy",   32'(bus.sched_busy),        32'd0);
    chk("lit_rst_frames", 32'(bus.frame_count),       32'd0);
    chk("lit_rst_build",  32'(bus.fb_build_response), 32'd0);
    chk("lit_rst_addr",   bus.fb_addr_echo,           32'd0);

    // Single command frame.
    bus.cmd_status = 8'h00; bus.cmd_code = 8'h81; bus.cmd_addr = 32'h1000_0040;
    bus.cmd_count = 6'd4; bus.cmd_is_read = 1'b1; bus.cmd_req = 1'b1;
    step();
    chk("lit_t1_ack",   32'(bus.cmd_ack),           32'd1);
    chk("lit_t1_build", 32'(bus.fb_build_response), 32'd1);
    chk("lit_t1_code",  32'(bus.fb_cmd_echo),       32'h81);
    chk("lit_t1_addr",  bus.fb_addr_echo,           32'h1000_0040);
    chk("lit_t1_count", 32'(bus.fb_data_count),     32'd4);
    chk("lit_t1_isrd",  32'(bus.fb_is_read),        32'd1);
    bus.cmd_req = 1'b0;
    finish_frame(3, 1'b0);
    chk("lit_t1_frames", 32'(bus.frame_count), 32'd1);

    // Ties after reset: cmd, evt, cmd, evt.
    do_reset();
    bus.cmd_code = 8'h02; bus.cmd_count = 6'd7; bus.cmd_is_read = 1'b1;
    bus.evt_status = 8'h5A; bus.evt_code = 8'hE1;
    bus.cmd_req = 1'b1; bus.evt_req = 1'b1;
    step();
    chk("lit_t2_grant0", 32'(bus.grant_id), 32'd0);
    chk("lit_t2_cack",   32'(bus.cmd_ack),  32'd1);
    bus.cmd_req = 1'b0;
    finish_frame(2, 1'b0);
    step();
    chk("lit_t2_eack",   32'(bus.evt_ack),       32'd1);
    chk("lit_t2_grant1", 32'(bus.grant_id),      32'd1);
    chk("lit_t2_ecount", 32'(bus.fb_data_count), 32'd0);
    chk("lit_t2_eisrd",  32'(bus.fb_is_read),    32'd0);
    chk("lit_t2_estat",  32'(bus.fb_status_code), 32'h5A);
    bus.evt_req = 1'b0;
    finish_frame(1, 1'b1);
    bus.cmd_req = 1'b1; bus.evt_req = 1'b1;
    step();
    chk("lit_t2b_grant0", 32'(bus.grant_id), 32'd0);
    bus.cmd_req = 1'b0;
    finish_frame(1, 1'b0);
    step();
    chk("lit_t2b_grant1", 32'(bus.grant_id), 32'd1);
    bus.evt_req = 1'b0;
    finish_frame(1, 1'b1);
    chk("lit_t2_frames", 32'(bus.frame_count), 32'd4);

    // Event raised while a command frame is in WAIT.
    bus.cmd_req = 1'b1;
    step();
    bus.cmd_req = 1'b0;
    step();
    bus.evt_code = 8'h33; bus.evt_req = 1'b1;
    repeat (4) begin
      step();
      chk("lit_t3_nobuild", 32'(bus.fb_build_response), 32'd0);
    end
    bus.fb_complete = 1'b1;
    step();
    bus.fb_complete = 1'b0;
    chk("lit_t3_cdone", 32'(bus.cmd_done), 32'd1);
    step();
    chk("lit_t3_noack", 32'(bus.evt_ack), 32'd0);
    step();
    chk("lit_t3_eack",  32'(bus.evt_ack),           32'd1);
    chk("lit_t3_build", 32'(bus.fb_build_response), 32'd1);
    bus.evt_req = 1'b0;
    finish_frame(2, 1'b1);

    // Builder busy blocks launch until it drops.
    bus.fb_busy = 1'b1; bus.cmd_req = 1'b1;
    repeat (4) begin
      step();
      chk("lit_t4_blocked", 32'(bus.sched_busy), 32'd0);
    end
    bus.fb_busy = 1'b0;
    step();
    chk("lit_t4_ack", 32'(bus.cmd_ack), 32'd1);
    bus.cmd_req = 1'b0;
    finish_frame(1, 1'b0);
    chk("lit_t4_frames", 32'(bus.frame_count), 32'd7);

    // Reset in WAIT with the request still up.
    bus.cmd_addr = 32'hDEAD_BEEF; bus.cmd_req = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("lit_t5_busy",   32'(bus.sched_busy),   32'd0);
    chk("lit_t5_addr",   bus.fb_addr_echo,      32'd0);
    chk("lit_t5_frames", 32'(bus.frame_count),  32'd0);
    rst = 1'b0;
    step();
    chk("lit_t5_relaunch", 32'(bus.cmd_ack), 32'd1);
    chk("lit_t5_addr2",    bus.fb_addr_echo, 32'hDEAD_BEEF);
    bus.cmd_req = 1'b0;
    finish_frame(2, 1'b0);

`ifdef RESP_SCHED_TIMEOUT_EN
    // Builder never completes: watchdog releases the requester.
    bus.cmd_req = 1'b1;
    step();
    bus.cmd_req = 1'b0;
    repeat (16) begin
      step();
      chk("lit_to_nodone", 32'(bus.cmd_done), 32'd0);
    end
    step();
    chk("lit_to_done",   32'(bus.cmd_done),     32'd1);
    chk("lit_to_flag",   32'(bus.timeout_flag), 32'd1);
    chk("lit_to_frames", 32'(bus.frame_count),  32'd1);
    step();
    bus.timeout_clr = 1'b1;
    step();
    bus.timeout_clr = 1'b0;
    chk("lit_to_clr", 32'(bus.timeout_flag), 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (bus.cmd_ack) bus.cmd_req = 1'b0;
      if (!bus.cmd_req) begin
        bus.cmd_status = 8'($urandom); bus.cmd_code = 8'($urandom);
        bus.cmd_addr = $urandom; bus.cmd_count = 6'($urandom);
        bus.cmd_is_read = 1'($urandom);
        if ($urandom_range(0, 5) == 0) bus.cmd_req = 1'b1;
      end
      if (bus.evt_ack) bus.evt_req = 1'b0;
      if (!bus.evt_req) begin
        bus.evt_status = 8'($urandom); bus.evt_code = 8'($urandom);
        if ($urandom_range(0, 5) == 0) bus.evt_req = 1'b1;
      end
      if (rst) begin
        bld_active = 0;
        bus.fb_complete = 1'b0;
      end else if (bus.fb_build_response) begin
        bld_active = 1;
        bld_cnt = TO_EN ? $urandom_range(1, 22) : $urandom_range(1, 8);
        bus.fb_complete = ($urandom_range(0, 7) == 0);
      end else if (bld_active) begin
        if (bld_cnt == 1) begin
          bus.fb_complete = 1'b1;
          bld_active = 0;
        end else begin
          bld_cnt--;
          bus.fb_complete = 1'b0;
        end
      end else begin
        bus.fb_complete = ($urandom_range(0, 9) == 0);
      end
      bus.fb_busy = ($urandom_range(0, 3) == 0);
      bus.timeout_clr = ($urandom_range(0, 11) == 0);
    end
    rst = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
